// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave that emulates the Pmod JSTK2 joystick: serves the 5-byte
// position/button packet on MISO and decodes the "set LED" command from MOSI.
module jstk2_spi_responder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PACKET_BYTES = 5,
  parameter logic [7:0]  LED_CMD      = 8'h84
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic [1:0]  buttons,
  output logic [23:0] led_rgb,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_prev, ss_prev, armed;
  logic [2:0]             bit_cnt, byte_cnt;
  logic [7:0]             tx_sh, rx, cmd, stage_r, stage_g, stage_b;
  logic [9:0]             snap_x, snap_y;
  logic [1:0]             snap_btn;

  // Metastability synchronizers for the asynchronous SPI pins
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise_c, sclk_fall_c, ss_rise_c, ss_fall_c;
  logic [7:0] rx_next_c;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise_c = ~sclk_prev & sclk_s;
  assign sclk_fall_c = sclk_prev & ~sclk_s;
  assign ss_rise_c   = ~ss_prev & ss_s;
  assign ss_fall_c   = ss_prev & ~ss_s;
  assign rx_next_c   = {rx[6:0], mosi_s};

  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [9:0] x,
                                         input logic [9:0] y, input logic [1:0] btn);
    if (32'(idx) >= PACKET_BYTES) return 8'h00;
    case (idx)
      3'd0:    return x[7:0];
      3'd1:    return {6'b0, x[9:8]};
      3'd2:    return y[7:0];
      3'd3:    return {6'b0, y[9:8]};
      3'd4:    return {6'b0, btn};
      default: return 8'h00;
    endcase
  endfunction

  // Frame FSM; armed blocks a frame start until ss has been seen high after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      led_rgb    <= 24'h0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      sclk_prev  <= 1'b0;
      ss_prev    <= 1'b1;
      armed      <= 1'b0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 3'd0;
      tx_sh      <= 8'h00;
      rx         <= 8'h00;
      cmd        <= 8'h00;
      stage_r    <= 8'h00;
      stage_g    <= 8'h00;
      stage_b    <= 8'h00;
      snap_x     <= 10'h0;
      snap_y     <= 10'h0;
      snap_btn   <= 2'b0;
    end else begin
      sclk_prev  <= sclk_s;
      ss_prev    <= ss_s;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (ss_s) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (ss_fall_c && armed) begin
            state    <= ACTIVE;
            snap_x   <= x_pos;
            snap_y   <= y_pos;
            snap_btn <= buttons;
            tx_sh    <= tx_byte(3'd0, x_pos, y_pos, buttons);
            miso     <= tx_byte(3'd0, x_pos, y_pos, buttons) >> 7 != 8'h00;
            miso_oe  <= 1'b1;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
          end
        end
        ACTIVE: begin
          if (ss_rise_c) begin
            state      <= IDLE;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            frame_done <= 1'b1;
            frame_err  <= (bit_cnt != 3'd0);
            if (cmd == LED_CMD && byte_cnt >= 3'd4 && bit_cnt == 3'd0)
              led_rgb <= {stage_r, stage_g, stage_b};
          end else if (sclk_rise_c) begin
            rx      <= rx_next_c;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
              case (byte_cnt)
                3'd0:    cmd     <= rx_next_c;
                3'd1:    stage_r <= rx_next_c;
                3'd2:    stage_g <= rx_next_c;
                3'd3:    stage_b <= rx_next_c;
                default: ;
              endcase
            end
          end else if (sclk_fall_c) begin
            if (bit_cnt == 3'd0) begin
              tx_sh <= tx_byte(byte_cnt, snap_x, snap_y, snap_btn);
              miso  <= tx_byte(byte_cnt, snap_x, snap_y, snap_btn) >> 7 != 8'h00;
            end else begin
              tx_sh <= {tx_sh[6:0], 1'b0};
              miso  <= tx_sh[6];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Randomized bench for jstk2_spi_responder: an SPI master task drives frames,
// a reference model predicts each frame, and a monitor checks at frame_done.
module tb_jstk2_spi_responder;

  localparam int unsigned HALF    = 6;
  localparam logic [7:0]  LED_CMD = 8'h84;

  logic        clk = 1'b0;
  logic        rst, sclk, ss, mosi;
  logic        miso, miso_oe;
  logic [9:0]  x_pos, y_pos;
  logic [1:0]  buttons;
  logic [23:0] led_rgb;
  logic        frame_done, frame_err;

  always #5 clk = ~clk;

  jstk2_spi_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .led_rgb(led_rgb), .frame_done(frame_done), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [63:0] rd;
    logic [3:0]  nfull;
    logic        err;
    logic [23:0] led;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] act_rd;
  logic [23:0] led_model;
  int          checks = 0;
  int          errors = 0;
  int          frames_issued = 0;
  int          frames_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Packet contents derived directly from the joystick values
  function automatic logic [7:0] model_byte(input int i, input int x, input int y, input int b);
    case (i)
      0:       return 8'(x % 256);
      1:       return 8'(x / 256);
      2:       return 8'(y % 256);
      3:       return 8'(y / 256);
      4:       return 8'(b);
      default: return 8'h00;
    endcase
  endfunction

  // Toggle sclk for nbits bits with ss already low; records MISO into act_rd
  task automatic spi_bits(input int nbits, input logic [63:0] tx, input int new_x,
                          output bit oe_seen);
    oe_seen = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      mosi = tx[8*(k/8) + 7 - (k%8)];
      repeat (HALF) @(negedge clk);
      act_rd[8*(k/8) + 7 - (k%8)] = miso;
      oe_seen |= miso_oe;
      sclk = 1'b1;
      if (k == 7 && new_x >= 0) x_pos = 10'(new_x);
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int nbits, input logic [63:0] tx, input int new_x);
    exp_t e;
    bit   oe;
    e.nfull = 4'(nbits / 8);
    e.err   = (nbits % 8) != 0;
    e.rd    = '0;
    for (int i = 0; i < 8; i++)
      e.rd[8*i +: 8] = model_byte(i, int'(x_pos), int'(y_pos), int'(buttons));
    if (!e.err && nbits / 8 >= 4 && tx[7:0] == LED_CMD)
      led_model = {tx[15:8], tx[23:16], tx[31:24]};
    e.led = led_model;
    exp_q.push_back(e);
    frames_issued++;
    act_rd = '0;
    @(negedge clk);
    ss = 1'b0;
    spi_bits(nbits, tx, new_x, oe);
    check("miso_oe_during_frame", 64'(oe), 64'(nbits > 0));
    repeat (HALF) @(negedge clk);
    ss   = 1'b0;
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (2*HALF) @(negedge clk);
  endtask

  // Monitor: every frame_done pops one prediction and compares the frame
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_err && !frame_done) check("err_without_done", 64'(frame_err), 64'(0));
      if (frame_done) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame_done", 64'(frame_done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 8; i++)
            if (i < int'(e.nfull))
              check($sformatf("byte%0d", i), 64'(act_rd[8*i +: 8]), 64'(e.rd[8*i +: 8]));
          check("frame_err", 64'(frame_err), 64'(e.err));
          check("led_rgb", 64'(led_rgb), 64'(e.led));
          check("miso_oe_after", 64'(miso_oe), 64'(0));
          check("miso_after", 64'(miso), 64'(0));
        end
      end
    end
  end

  initial begin
    bit          oe;
    int          r, nbits;
    logic [63:0] tx;
    rst = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    x_pos = '0; y_pos = '0; buttons = '0; led_model = '0; act_rd = '0;
    repeat (5) @(negedge clk);
    check("rst_miso", 64'(miso), 64'(0));
    check("rst_miso_oe", 64'(miso_oe), 64'(0));
    check("rst_led", 64'(led_rgb), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));
    check("rst_err", 64'(frame_err), 64'(0));
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Directed frames from the joystick test plan
    x_pos = 10'h2A5; y_pos = 10'h1FF; buttons = 2'b10;
    spi_frame(40, 64'h0, -1);
    spi_frame(40, 64'h0, 0);
    spi_frame(40, 64'h0, -1);
    spi_frame(40, 64'h00_33_22_11_84, -1);
    spi_frame(40, 64'h00_66_55_44_00, -1);
    spi_frame(56, 64'h0, -1);
    spi_frame(12, 64'h00_00_00_AA_84, -1);
    spi_frame(64, 64'h01_02_03_04_0A_0B_0C_84, -1);

    // Reset mid-frame with ss held low: frame is abandoned, no output afterwards
    @(negedge clk);
    ss = 1'b0;
    spi_bits(12, 64'h00_00_77_66_55_84, -1, oe);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    led_model = '0;
    @(negedge clk);
    check("abort_led", 64'(led_rgb), 64'(0));
    check("abort_miso_oe", 64'(miso_oe), 64'(0));
    spi_bits(16, 64'hFFFF, -1, oe);
    check("abort_no_output", 64'(oe), 64'(0));
    check("abort_miso", 64'(miso), 64'(0));
    ss = 1'b1;
    repeat (2*HALF) @(negedge clk);
    x_pos = 10'h155; y_pos = 10'h3C3; buttons = 2'b01;
    spi_frame(40, 64'h0, -1);

    // Random frames: full, long, and partial lengths with random commands
    for (int n = 0; n < 14; n++) begin
      x_pos   = 10'($urandom_range(0, 1023));
      y_pos   = 10'($urandom_range(0, 1023));
      buttons = 2'($urandom_range(0, 3));
      tx      = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) tx[7:0] = LED_CMD;
      r = int'($urandom_range(0, 3));
      case (r)
        0:       nbits = 40;
        1:       nbits = 56;
        2:       nbits = 64;
        default: nbits = int'($urandom_range(1, 63));
      endcase
      spi_frame(nbits, tx, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1023)) : -1);
    end

    repeat (20) @(negedge clk);
    check("pending_frames", 64'(exp_q.size()), 64'(0));
    check("frame_count", 64'(frames_seen), 64'(frames_issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
